// File: rtl/sccb_write_master.sv
// sccb_write_master
//   Bit-level SCCB/I2C write engine. Each accepted command {reg_addr, wr_data}
//   becomes one bus transaction:
//   START, {DEV_ADDR,W}, reg_addr[15:8], reg_addr[7:0], wr_data, STOP.
//   The bus is open-drain: an _o of 0 pulls the line low, 1 releases it.
//   Each _t output mirrors its _o so the pair can drive an IOBUF directly.
//
//   Optional build macro: SCCB_STRETCH_EN
//     When defined, a slave holding SCL low after it is released in Q2
//     (clock stretching) pauses the quarter counter.
//     When undefined, scl_i is ignored and the timing is fixed.
//
// Ports
//   clk_in, rst_in        clock; synchronous active-high reset
//   cmd_data[23:0]        {reg_addr[15:0], wr_data[7:0]}
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   resp_valid/resp_nack  one-cycle result pulse after STOP; nack=1 if any byte was NACKed
//   busy                  high from accept through the resp_valid cycle
//   scl_i/sda_i           resolved bus levels
//   scl_o/sda_o/_t        open-drain drives and tristate enables
//
// state   | meaning
// S_IDLE  | lines released, cmd_ready high
// S_START | SDA low while SCL high, 2 quarters
// S_BIT   | 9 bit slots per byte (8 data + ACK), 4 quarters each
// S_STOP  | SCL/SDA low, SCL high, then SDA released for 2 quarters
// S_DONE  | one-cycle response pulse
module sccb_write_master #(
   parameter int         CLK_DIV  = 250,
   parameter logic [6:0] DEV_ADDR = 7'h3C
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [23:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic        resp_valid,
   output logic        resp_nack,
   output logic        busy,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        scl_o,
   output logic        sda_o,
   output logic        scl_t,
   output logic        sda_t
);

   localparam int             QW   = $clog2(CLK_DIV);
   localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);
   localparam logic [QW-1:0]  QONE = QW'(1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [QW-1:0] qcnt;
   logic [1:0]    quarter;
   logic [3:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic [7:0]    shreg;
   logic [23:0]   cmd_reg;
   logic          nack;
   logic          tick;
   logic          ack_slot;
   logic          hold;

`ifdef SCCB_STRETCH_EN
   // Slave is stretching: SCL has been released in Q2 but the bus is still low.
   assign hold = (state == S_BIT) && (quarter == 2'd2) && (qcnt == '0) && !scl_i;
`else
   logic unused_scl;
   assign unused_scl = scl_i;
   assign hold       = 1'b0;
`endif

   assign tick     = (qcnt == QMAX);
   assign ack_slot = (state == S_BIT) && (bit_idx == 4'd8) && (quarter == 2'd3) && tick;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_valid) state_nxt = S_START;
         S_START: if (tick && quarter == 2'd1) state_nxt = S_BIT;
         S_BIT:   if (ack_slot && (sda_i || byte_idx == 2'd3)) state_nxt = S_STOP;
         S_STOP:  if (tick && quarter == 2'd3) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      scl_o      = 1'b1;
      sda_o      = 1'b1;
      cmd_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE:  cmd_ready = 1'b1;
         S_START: sda_o = 1'b0;
         S_BIT: begin
            scl_o = quarter[1];
            sda_o = (bit_idx == 4'd8) ? 1'b1 : shreg[7];
         end
         S_STOP: begin
            scl_o = (quarter != 2'd0);
            sda_o = quarter[1];
         end
         S_DONE:  resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign scl_t     = scl_o;
   assign sda_t     = sda_o;
   assign busy      = (state != S_IDLE);
   assign resp_nack = (state == S_DONE) && nack;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= S_IDLE;
         qcnt     <= '0;
         quarter  <= 2'd0;
         bit_idx  <= 4'd0;
         byte_idx <= 2'd0;
         shreg    <= 8'h00;
         cmd_reg  <= 24'h0;
         nack     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cmd_reg  <= cmd_data;
                  shreg    <= {DEV_ADDR, 1'b0};
                  // The accept cycle is counted as the first cycle of START, so
                  // the response lands 150*CLK_DIV cycles after accept and a
                  // back-to-back command is accepted 150*CLK_DIV+1 cycles later.
                  qcnt     <= QONE;
                  quarter  <= 2'd0;
                  bit_idx  <= 4'd0;
                  byte_idx <= 2'd0;
                  nack     <= 1'b0;
               end
            end
            S_START, S_BIT, S_STOP: begin
               if (!hold) begin
                  qcnt <= tick ? '0 : qcnt + QONE;
                  if (tick) begin
                     quarter <= quarter + 2'd1;
                     if (state == S_START && quarter == 2'd1) quarter <= 2'd0;
                     if (state == S_BIT && quarter == 2'd3) begin
                        if (bit_idx != 4'd8) begin
                           bit_idx <= bit_idx + 4'd1;
                           shreg   <= {shreg[6:0], 1'b0};
                        end else begin
                           bit_idx <= 4'd0;
                           if (sda_i) begin
                              nack <= 1'b1;
                           end else if (byte_idx != 2'd3) begin
                              byte_idx <= byte_idx + 2'd1;
                              case (byte_idx)
                                 2'd0:    shreg <= cmd_reg[23:16];
                                 2'd1:    shreg <= cmd_reg[15:8];
                                 default: shreg <= cmd_reg[7:0];
                              endcase
                           end
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_write_master.sv
module tb_sccb_write_master;

   localparam int CLK_DIV = 4;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic [23:0] cmd_data = 24'h0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready, resp_valid, resp_nack, busy;
   logic        scl_i, sda_i, scl_o, sda_o, scl_t, sda_t;

   logic        slave_scl = 1'b1;
   logic        slave_sda = 1'b1;

   assign scl_i = scl_o & slave_scl;
   assign sda_i = sda_o & slave_sda;

   sccb_write_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h3C)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .resp_valid(resp_valid), .resp_nack(resp_nack), .busy(busy),
      .scl_i(scl_i), .sda_i(sda_i),
      .scl_o(scl_o), .sda_o(sda_o), .scl_t(scl_t), .sda_t(sda_t)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- I2C slave model ----------------
   logic [6:0] slave_addr = 7'h3C;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;
   logic       active = 1'b0, in_ack = 1'b0, acked = 1'b0;
   int         bitcnt = 0, byte_n = 0;
   logic [7:0] sh = 8'h00;
   logic [7:0] rx_q[$];
   int         n_start = 0, n_stop = 0;
   logic       stretch_req = 1'b0, stretching = 1'b0;
   int         str_cnt = 0;

   always @(posedge clk_in) begin
      if (prev_scl && scl_i && prev_sda && !sda_i) begin
         n_start++;
         active = 1'b1; in_ack = 1'b0; bitcnt = 0; byte_n = 0;
         slave_sda <= 1'b1;
      end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
         n_stop++;
         active = 1'b0; in_ack = 1'b0;
         slave_sda <= 1'b1;
      end else if (active) begin
         if (!prev_scl && scl_i) begin
            if (!in_ack) begin
               sh = {sh[6:0], sda_i};
               bitcnt++;
            end
         end else if (prev_scl && !scl_i) begin
            if (in_ack) begin
               slave_sda <= 1'b1;
               in_ack = 1'b0; bitcnt = 0; byte_n++;
               if (!acked) active = 1'b0;
            end else if (bitcnt == 8) begin
               if (byte_n == 0) acked = (sh[7:1] == slave_addr) && !sh[0];
               else begin
                  rx_q.push_back(sh);
                  acked = 1'b1;
               end
               if (acked) slave_sda <= 1'b0;
               in_ack = 1'b1;
            end else if (stretch_req && byte_n == 1 && bitcnt == 3) begin
               slave_scl <= 1'b0;
               stretching = 1'b1; str_cnt = 0; stretch_req = 1'b0;
            end
         end
      end
      if (stretching) begin
         if (scl_o) str_cnt++;
         if (str_cnt == 20) begin
            slave_scl <= 1'b1;
            stretching = 1'b0;
         end
      end
      prev_scl = scl_i;
      prev_sda = sda_i;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic        nack;
      int          lat;
      int          nbytes;
      logic [23:0] bytes;
   } exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   acc_log[$];

   task automatic expect_txn(input logic nack, input int lat, input int nbytes, input logic [23:0] bytes);
      exp_t e;
      e.nack = nack; e.lat = lat; e.nbytes = nbytes; e.bytes = bytes;
      exp_q.push_back(e);
   endtask

   always @(negedge clk_in) begin
      if (cmd_valid && cmd_ready) begin
         acc_q.push_back(cyc + 1);
         acc_log.push_back(cyc + 1);
      end
      if (resp_valid) begin
         if (exp_q.size() == 0 || acc_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_resp actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            exp_t        e;
            int          t;
            logic [23:0] b;
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            b = e.bytes;
            check("resp_nack", resp_nack, e.nack);
            check("latency", cyc + 1 - t, e.lat);
            check("busy_at_resp", busy, 1'b1);
            check("rx_count", rx_q.size(), e.nbytes);
            for (int i = 0; i < e.nbytes; i++)
               if (i < rx_q.size()) check("rx_byte", rx_q[i], b[23 - 8*i -: 8]);
            check("start_count", n_start, 1);
            check("stop_count", n_stop, 1);
         end
         rx_q.delete();
         n_start = 0;
         n_stop = 0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_hs(input int bound);
      bit ok = 1'b0;
      for (int i = 0; i < bound && !ok; i++) begin
         @(negedge clk_in);
         if (cmd_valid && cmd_ready) ok = 1'b1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL handshake_timeout actual=none required=accept (cycle %0d)", cyc);
      end else begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic issue(input logic [23:0] d);
      cmd_data  = d;
      cmd_valid = 1'b1;
      wait_hs(3000);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk_in);
      if (exp_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk_in);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_resp_valid", resp_valid, 1'b0);
      check("rst_resp_nack", resp_nack, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_lines", {scl_o, scl_t, sda_o, sda_t}, 4'hF);
      @(posedge clk_in);
      #1 rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;

      // Plain write, acked throughout.
      expect_txn(1'b0, 600, 3, 24'h300882);
      issue(24'h300882);
      wait_drain(2000);

      // No slave at the device address: NACK on the address byte.
      slave_addr = 7'h21;
      expect_txn(1'b1, 168, 0, 24'h0);
      issue(24'h310311);
      wait_drain(2000);
      slave_addr = 7'h3C;

      // cmd_valid held high across three commands; data changes while busy ignored.
      n = acc_log.size();
      expect_txn(1'b0, 600, 3, 24'h3A5C3F);
      expect_txn(1'b0, 600, 3, 24'hFFFF00);
      expect_txn(1'b0, 600, 3, 24'h0000FF);
      cmd_data  = 24'h3A5C3F;
      cmd_valid = 1'b1;
      wait_hs(3000);
      repeat (10) @(posedge clk_in);
      #1 cmd_data = 24'h123456;
      @(negedge clk_in);
      check("ready_while_busy", cmd_ready, 1'b0);
      check("busy_mid_txn", busy, 1'b1);
      repeat (480) @(posedge clk_in);
      #1 cmd_data = 24'hFFFF00;
      wait_hs(3000);
      repeat (10) @(posedge clk_in);
      #1 cmd_data = 24'hABCDEF;
      repeat (480) @(posedge clk_in);
      #1 cmd_data = 24'h0000FF;
      wait_hs(3000);
      cmd_valid = 1'b0;
      wait_drain(3000);
      if (acc_log.size() >= n + 3) begin
         check("accept_gap_1", acc_log[n+1] - acc_log[n], 601);
         check("accept_gap_2", acc_log[n+2] - acc_log[n+1], 601);
      end else begin
         checks++; failures++;
         $display("FAIL accept_count actual=%0d required=3", acc_log.size() - n);
      end

      // Reset pulse mid-transfer: lines released, idle, no response.
      issue(24'h300882);
      repeat (299) @(posedge clk_in);
      #1 rst_in = 1'b1;
      @(posedge clk_in);
      #1 rst_in = 1'b0;
      @(negedge clk_in);
      check("mid_rst_scl", scl_o, 1'b1);
      check("mid_rst_sda", sda_o, 1'b1);
      check("mid_rst_ready", cmd_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_resp", resp_valid, 1'b0);
      acc_q.delete();
      repeat (700) @(posedge clk_in);
      #1;
      rx_q.delete();
      n_start = 0;
      n_stop = 0;

      // Recovery after reset.
      expect_txn(1'b0, 600, 3, 24'h503D81);
      issue(24'h503D81);
      wait_drain(2000);

`ifdef SCCB_STRETCH_EN
      stretch_req = 1'b1;
      expect_txn(1'b0, 620, 3, 24'h300882);
      issue(24'h300882);
      wait_drain(2000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
